// File: rtl/ethrxfilter_pkg.sv
// Shared definitions for the Ethernet receive filter: status codes, length limits,
// FSM state encoding and the word record carried through the output skid.
package ethrxfilter_pkg;

   localparam logic [2:0] ST_OK   = 3'd0;
   localparam logic [2:0] ST_GEN  = 3'd1;
   localparam logic [2:0] ST_CRC  = 3'd2;
   localparam logic [2:0] ST_RUNT = 3'd3;
   localparam logic [2:0] ST_OVER = 3'd4;
   localparam logic [2:0] ST_ADDR = 3'd5;

   localparam logic [10:0] MIN_LEN_DEF = 11'd14;
   localparam logic [10:0] MAX_LEN_DEF = 11'd1514;
   localparam logic [15:0] BCAST_WORD  = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_XFER,
      S_STATUS,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [15:0] dat;
      logic        last;
      logic        odd;
   } word_t;

   // Buffer words hold {octet 2n+1, octet 2n}; mymac[47:40] is octet 0.
   function automatic logic [15:0] mac_word(input logic [47:0] mac, input logic [1:0] idx);
      case (idx)
         2'd0:    return {mac[39:32], mac[47:40]};
         2'd1:    return {mac[23:16], mac[31:24]};
         default: return {mac[7:0],   mac[15:8]};
      endcase
   endfunction

endpackage

// File: rtl/ethrxfilter_if.sv
// Host-side payload stream: valid/ready words with last/odd framing marks.
interface ethrxfilter_if;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        out_odd;

   modport master (output out_data, out_valid, out_last, out_odd, input out_ready);
   modport slave  (input out_data, out_valid, out_last, out_odd, output out_ready);
endinterface

// File: rtl/ethrxfilter_skid.sv
// Output register plus one skid entry; issue_ok says a read launched now will have a slot
// when its data returns a clock later, so no word is lost while out_rdy is low.
module ethrxfilter_skid
   import ethrxfilter_pkg::*;
(
   input  logic  clk,
   input  logic  clr,
   input  logic  in_vld,
   input  word_t in_dat,
   output logic  issue_ok,
   output logic  out_vld,
   output word_t out_dat,
   input  logic  out_rdy
);

   logic  skid_vld;
   word_t skid_dat;
   logic  pop;
   logic [1:0] occ;

   assign pop = out_vld & out_rdy;
   // Entries held after this clock, counting the word arriving now.
   assign occ      = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, in_vld} - {1'b0, pop};
   assign issue_ok = (occ <= 2'd1);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         out_vld  <= 1'b0;
         out_dat  <= '0;
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else if (!out_vld || pop) begin
         if (skid_vld) begin
            out_vld  <= 1'b1;
            out_dat  <= skid_dat;
            skid_vld <= in_vld;
            skid_dat <= in_dat;
         end else begin
            out_vld <= in_vld;
            if (in_vld) out_dat <= in_dat;
         end
      end else if (in_vld) begin
         skid_vld <= 1'b1;
         skid_dat <= in_dat;
      end
   end

endmodule

// File: rtl/ethrxfilter.sv
// Ethernet receive filter: error/length/DA check, accepted payload streamed with 1-clk-latency reads.
// ETH_RXFILT_PROMISC_EN adds a promisc input that bypasses the destination address check.
module ethrxfilter
   import ethrxfilter_pkg::*;
#(
   parameter logic [10:0] MIN_LEN = MIN_LEN_DEF,
   parameter logic [10:0] MAX_LEN = MAX_LEN_DEF
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          rxrdy,
   input  logic [10:0]   rxcntb,
   input  logic          err_gen,
   input  logic          err_crc,
   input  logic [47:0]   mymac,
`ifdef ETH_RXFILT_PROMISC_EN
   input  logic          promisc,
`endif
   output logic [9:0]    bufaddr,
   input  logic [15:0]   bufdata,
   output logic          rxdone,
   ethrxfilter_if.master out,
   output logic          st_valid,
   output logic [2:0]    st_code,
   output logic [10:0]   st_len,
   output logic [15:0]   dropcnt
);

   state_t      state_q, state_d;
   logic [9:0]  addr_q, addr_d;
   logic [1:0]  chk_q;
   logic [10:0] len_q;
   logic        eg_q, ec_q;
   logic        uc_q, bc_q;
   logic [2:0]  code_q, pre_code;
   logic [15:0] drop_q;
   logic        rd_pend_q, pend_last_q;
   logic        issue, issue_ok, addr_hit, addr_ok, last_hs, last_rd;
   logic [10:0] nwords;
   word_t       in_w, out_w;
   logic        out_vld;

   assign nwords  = {1'b0, len_q[10:1]} + {10'd0, len_q[0]};
   assign last_rd = ({1'b0, addr_q} == (nwords - 11'd1));

   always_comb begin
      pre_code = ST_OK;
      if (eg_q)                pre_code = ST_GEN;
      else if (ec_q)           pre_code = ST_CRC;
      else if (len_q < MIN_LEN) pre_code = ST_RUNT;
      else if (len_q > MAX_LEN) pre_code = ST_OVER;
   end

   // Third DA word is on bufdata while chk_q == 3; the first two are folded into uc_q/bc_q.
   assign addr_hit = (uc_q & (bufdata == mac_word(mymac, 2'd2))) |
                     (bc_q & (bufdata == BCAST_WORD));
`ifdef ETH_RXFILT_PROMISC_EN
   assign addr_ok = addr_hit | promisc;
`else
   assign addr_ok = addr_hit;
`endif

   assign last_hs = out_vld & out.out_ready & out_w.last;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            addr_d = '0;
            if (rxrdy) state_d = S_CHECK;
         end
         S_CHECK: begin
            // Rewind to word 0 early so the payload re-read starts on XFER entry.
            addr_d = chk_q[1] ? 10'd0 : addr_q + 10'd1;
            if (chk_q == 2'd0 && pre_code != ST_OK) begin
               state_d = S_STATUS;
               addr_d  = '0;
            end else if (chk_q == 2'd3) begin
               state_d = addr_ok ? S_XFER : S_STATUS;
            end
         end
         S_XFER: begin
            issue = ({1'b0, addr_q} < nwords) && issue_ok;
            if (issue)   addr_d  = addr_q + 10'd1;
            if (last_hs) state_d = S_STATUS;
         end
         S_STATUS: begin
            addr_d  = '0;
            state_d = S_DONE;
         end
         S_DONE: begin
            addr_d = '0;
            if (!rxrdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         addr_q      <= '0;
         chk_q       <= '0;
         len_q       <= '0;
         eg_q        <= 1'b0;
         ec_q        <= 1'b0;
         uc_q        <= 1'b0;
         bc_q        <= 1'b0;
         code_q      <= ST_OK;
         drop_q      <= '0;
         rd_pend_q   <= 1'b0;
         pend_last_q <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         rd_pend_q   <= issue;
         pend_last_q <= issue & last_rd;
         if (state_q == S_IDLE && rxrdy) begin
            len_q <= rxcntb;
            eg_q  <= err_gen;
            ec_q  <= err_crc;
         end
         if (state_q == S_CHECK) begin
            chk_q <= chk_q + 2'd1;
            if (chk_q == 2'd1) begin
               uc_q <= (bufdata == mac_word(mymac, 2'd0));
               bc_q <= (bufdata == BCAST_WORD);
            end else if (chk_q == 2'd2) begin
               uc_q <= uc_q & (bufdata == mac_word(mymac, 2'd1));
               bc_q <= bc_q & (bufdata == BCAST_WORD);
            end
            if (chk_q == 2'd0 && pre_code != ST_OK) code_q <= pre_code;
            else if (chk_q == 2'd3)                 code_q <= addr_ok ? ST_OK : ST_ADDR;
         end else begin
            chk_q <= '0;
         end
         if (state_q == S_STATUS && code_q != ST_OK && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
      end
   end

   assign in_w.dat  = bufdata;
   assign in_w.last = pend_last_q;
   assign in_w.odd  = pend_last_q & len_q[0];

   ethrxfilter_skid u_skid (
      .clk      (clk),
      .clr      (clr),
      .in_vld   (rd_pend_q),
      .in_dat   (in_w),
      .issue_ok (issue_ok),
      .out_vld  (out_vld),
      .out_dat  (out_w),
      .out_rdy  (out.out_ready)
   );

   assign out.out_valid = out_vld;
   assign out.out_data  = out_w.dat;
   assign out.out_last  = out_w.last;
   assign out.out_odd   = out_w.odd;

   assign bufaddr  = addr_q;
   assign rxdone   = (state_q == S_DONE);
   assign st_valid = (state_q == S_STATUS);
   assign st_code  = st_valid ? code_q : 3'd0;
   assign st_len   = st_valid ? len_q : 11'd0;
   assign dropcnt  = drop_q;

endmodule

// File: tb/tb_ethrxfilter.sv
// Scoreboard bench for ethrxfilter: expected words/status queued at stimulus time, compared per test.
module tb_ethrxfilter;
   import ethrxfilter_pkg::*;

   localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
   localparam logic [47:0] OTHER = 48'h00_11_22_33_44_56;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic rxrdy = 1'b0;
   logic [10:0] rxcntb = '0;
   logic err_gen = 1'b0, err_crc = 1'b0;
   logic [47:0] mymac = MAC;
   logic [9:0] bufaddr;
   logic [15:0] bufdata = '0;
   logic rxdone, st_valid;
   logic [2:0] st_code;
   logic [10:0] st_len;
   logic [15:0] dropcnt;
`ifdef ETH_RXFILT_PROMISC_EN
   logic promisc = 1'b0;
`endif

   ethrxfilter_if oif();

   ethrxfilter dut (
      .clk(clk), .clr(clr), .rxrdy(rxrdy), .rxcntb(rxcntb), .err_gen(err_gen), .err_crc(err_crc),
      .mymac(mymac),
`ifdef ETH_RXFILT_PROMISC_EN
      .promisc(promisc),
`endif
      .bufaddr(bufaddr), .bufdata(bufdata), .rxdone(rxdone), .out(oif),
      .st_valid(st_valid), .st_code(st_code), .st_len(st_len), .dropcnt(dropcnt)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:1023];
   always @(posedge clk) bufdata <= mem[bufaddr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;
   int exp_drop = 0;
   word_t exp_q[$], obs_q[$];
   logic [13:0] exp_st_q[$], obs_st_q[$];
   int rdy_cyc, first_vld, first_hs, last_hs, stall_viol;
   bit stalled = 1'b0;
   word_t hold;
   bit bp_mode = 1'b0;

   // out_ready driver: steady 1, or the 1,0,0,1 pattern.
   initial begin
      logic [3:0] pat;
      int ph;
      pat = 4'b1001;
      ph = 0;
      oif.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bp_mode) begin
            oif.out_ready = pat[ph];
            ph = (ph + 1) % 4;
         end else begin
            oif.out_ready = 1'b1;
            ph = 0;
         end
      end
   end

   always @(negedge clk) begin
      word_t w;
      w.dat = oif.out_data; w.last = oif.out_last; w.odd = oif.out_odd;
      if (oif.out_valid) begin
         if (first_vld < 0) first_vld = cyc;
         if (stalled && w !== hold) stall_viol++;
         if (oif.out_ready) begin
            obs_q.push_back(w);
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            hold = w;
         end
      end else begin
         if (stalled) stall_viol++;
         stalled = 1'b0;
      end
      if (st_valid) obs_st_q.push_back({st_code, st_len});
   end

   task automatic send_frame(input logic [47:0] dst, input int len, input logic eg, input logic ec,
                             input bit accept, input logic [2:0] code);
      int nw;
      word_t w;
      nw = (len + 1) / 2;
      mem[0] = {dst[39:32], dst[47:40]};
      mem[1] = {dst[23:16], dst[31:24]};
      mem[2] = {dst[7:0], dst[15:8]};
      for (int i = 3; i < nw; i++) mem[i] = 16'($urandom);
      if (accept) begin
         for (int i = 0; i < nw; i++) begin
            w.dat = mem[i]; w.last = (i == nw - 1); w.odd = (i == nw - 1) && len[0];
            exp_q.push_back(w);
         end
      end
      if (code != ST_OK) exp_drop++;
      exp_st_q.push_back({code, 11'(len)});
      first_vld = -1; first_hs = -1; last_hs = -1;
      rxcntb = 11'(len); err_gen = eg; err_crc = ec;
      rdy_cyc = cyc + 1;
      rxrdy = 1'b1;
   endtask

   task automatic finish_frame(output bit to, output bit held, output bit stuck);
      int n;
      n = 0;
      while (!rxdone && n < 5000) begin @(posedge clk); #1; n++; end
      to = !rxdone;
      repeat (3) begin @(posedge clk); #1; end
      held = rxdone;
      rxrdy = 1'b0; err_gen = 1'b0; err_crc = 1'b0;
      n = 0;
      while (rxdone && n < 20) begin @(posedge clk); #1; n++; end
      stuck = rxdone;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset;
      clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({oif.out_valid, oif.out_data, oif.out_last, oif.out_odd, rxdone, st_valid, st_code,
           st_len, dropcnt, bufaddr} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs valid=%b data=%h rxdone=%b st=%b drop=%h addr=%h required all 0",
                  oif.out_valid, oif.out_data, rxdone, st_valid, dropcnt, bufaddr);
      end
      clr = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      n_tests++;
      if (rxdone !== 1'b0 || st_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle rxdone=%b st_valid=%b required 0 0", rxdone, st_valid);
      end
   endtask

   task automatic test_unicast;
      bit to, held, stuck;
      word_t e, o;
      logic [13:0] es;
      int nexp;
      send_frame(MAC, 64, 1'b0, 1'b0, 1'b1, ST_OK);
      nexp = exp_q.size();
      finish_frame(to, held, stuck);
      n_tests++;
      if (to || !held || stuck) begin
         n_fail++;
         $display("FAIL uni_rxdone timeout=%0d held=%0d stuck=%0d required 0 1 0", to, held, stuck);
      end
      n_tests++;
      if (obs_q.size() != nexp) begin
         n_fail++;
         $display("FAIL uni_count got %0d required %0d", obs_q.size(), nexp);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL uni_word got %h required %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
      es = exp_st_q.pop_front();
      n_tests++;
      if (obs_st_q.size() != 1 || obs_st_q[0] !== es) begin
         n_fail++;
         $display("FAIL uni_status n=%0d got %h required %h", obs_st_q.size(), obs_st_q[0], es);
      end
      obs_st_q.delete(); exp_st_q.delete();
      n_tests++;
      if (first_vld < 0 || first_vld - rdy_cyc > 6) begin
         n_fail++;
         $display("FAIL uni_latency got %0d required <=6", first_vld - rdy_cyc);
      end
      n_tests++;
      if (last_hs - first_hs != nexp - 1) begin
         n_fail++;
         $display("FAIL uni_bubbles span %0d required %0d", last_hs - first_hs, nexp - 1);
      end
   endtask

   task automatic test_broadcast;
      bit to, held, stuck;
      word_t e, o;
      logic [13:0] es;
      send_frame(BCAST, 61, 1'b0, 1'b0, 1'b1, ST_OK);
      finish_frame(to, held, stuck);
      n_tests++;
      if (obs_q.size() != 31) begin
         n_fail++;
         $display("FAIL bc_count got %0d required 31", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL bc_word got %h required %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
      es = exp_st_q.pop_front();
      n_tests++;
      if (to || stuck || obs_st_q.size() != 1 || obs_st_q[0] !== es) begin
         n_fail++;
         $display("FAIL bc_status n=%0d got %h required %h", obs_st_q.size(), obs_st_q[0], es);
      end
      obs_st_q.delete(); exp_st_q.delete();
   endtask

   task automatic test_errors;
      bit to, held, stuck;
      logic [13:0] es;
      send_frame(MAC, 64, 1'b1, 1'b1, 1'b0, ST_GEN);
      finish_frame(to, held, stuck);
      n_tests++;
      if (to || !held || stuck) begin
         n_fail++;
         $display("FAIL err_rxdone timeout=%0d held=%0d stuck=%0d required 0 1 0", to, held, stuck);
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL err_nowords got %0d words required 0", obs_q.size());
      end
      es = exp_st_q.pop_front();
      n_tests++;
      if (obs_st_q.size() != 1 || obs_st_q[0] !== es) begin
         n_fail++;
         $display("FAIL err_status n=%0d got %h required %h", obs_st_q.size(), obs_st_q[0], es);
      end
      n_tests++;
      if (dropcnt !== 16'(exp_drop)) begin
         n_fail++;
         $display("FAIL err_dropcnt got %0d required %0d", dropcnt, exp_drop);
      end
      obs_q.delete(); exp_q.delete(); obs_st_q.delete(); exp_st_q.delete();
   endtask

   task automatic test_reject_codes;
      bit to, held, stuck;
      logic [13:0] es;
      logic [47:0] t_dst [4];
      int t_len [4];
      logic t_ec [4];
      logic [2:0] t_code [4];
      t_dst[0] = MAC;   t_len[0] = 13;   t_ec[0] = 1'b0; t_code[0] = ST_RUNT;
      t_dst[1] = MAC;   t_len[1] = 1515; t_ec[1] = 1'b0; t_code[1] = ST_OVER;
      t_dst[2] = OTHER; t_len[2] = 64;   t_ec[2] = 1'b0; t_code[2] = ST_ADDR;
      t_dst[3] = MAC;   t_len[3] = 64;   t_ec[3] = 1'b1; t_code[3] = ST_CRC;
      for (int k = 0; k < 4; k++) begin
         send_frame(t_dst[k], t_len[k], 1'b0, t_ec[k], 1'b0, t_code[k]);
         finish_frame(to, held, stuck);
         es = exp_st_q.pop_front();
         n_tests++;
         if (to || stuck || obs_q.size() != 0 || obs_st_q.size() != 1 || obs_st_q[0] !== es) begin
            n_fail++;
            $display("FAIL reject_%0d words=%0d n=%0d got %h required %h", k, obs_q.size(),
                     obs_st_q.size(), obs_st_q[0], es);
         end
         n_tests++;
         if (dropcnt !== 16'(exp_drop)) begin
            n_fail++;
            $display("FAIL reject_%0d_dropcnt got %0d required %0d", k, dropcnt, exp_drop);
         end
         obs_q.delete(); exp_q.delete(); obs_st_q.delete(); exp_st_q.delete();
      end
`ifdef ETH_RXFILT_PROMISC_EN
      promisc = 1'b1;
      send_frame(OTHER, 64, 1'b0, 1'b0, 1'b1, ST_OK);
      finish_frame(to, held, stuck);
      es = exp_st_q.pop_front();
      n_tests++;
      if (obs_q.size() != 32 || obs_st_q.size() != 1 || obs_st_q[0] !== es) begin
         n_fail++;
         $display("FAIL promisc words=%0d got %h required 32 words %h", obs_q.size(), obs_st_q[0], es);
      end
      promisc = 1'b0;
      obs_q.delete(); exp_q.delete(); obs_st_q.delete(); exp_st_q.delete();
`endif
   endtask

   task automatic test_backpressure;
      bit to, held, stuck;
      word_t e, o;
      logic [13:0] es;
      stall_viol = 0;
      bp_mode = 1'b1;
      send_frame(MAC, 100, 1'b0, 1'b0, 1'b1, ST_OK);
      finish_frame(to, held, stuck);
      bp_mode = 1'b0;
      n_tests++;
      if (obs_q.size() != 50) begin
         n_fail++;
         $display("FAIL bp_count got %0d required 50", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL bp_word got %h required %h", o, e); end
      end
      n_tests++;
      if (stall_viol != 0) begin
         n_fail++;
         $display("FAIL bp_stable got %0d changes while stalled required 0", stall_viol);
      end
      es = exp_st_q.pop_front();
      n_tests++;
      if (to || stuck || obs_st_q.size() != 1 || obs_st_q[0] !== es) begin
         n_fail++;
         $display("FAIL bp_status n=%0d got %h required %h", obs_st_q.size(), obs_st_q[0], es);
      end
      obs_q.delete(); exp_q.delete(); obs_st_q.delete(); exp_st_q.delete();
   endtask

   task automatic test_clr_midframe;
      bit to, held, stuck;
      word_t e, o;
      int n;
      send_frame(MAC, 100, 1'b0, 1'b0, 1'b1, ST_OK);
      n = 0;
      while (obs_q.size() < 10 && n < 200) begin @(posedge clk); #1; n++; end
      n_tests++;
      if (obs_q.size() < 10) begin
         n_fail++;
         $display("FAIL clr_reach_word10 got %0d words required 10", obs_q.size());
      end
      clr = 1'b1;
      #1;
      n_tests++;
      if ({oif.out_valid, oif.out_data, oif.out_last, oif.out_odd, rxdone, st_valid, st_code,
           st_len, dropcnt, bufaddr} !== '0) begin
         n_fail++;
         $display("FAIL clr_outputs valid=%b data=%h drop=%h addr=%h required all 0",
                  oif.out_valid, oif.out_data, dropcnt, bufaddr);
      end
      rxrdy = 1'b0;
      exp_drop = 0;
      @(posedge clk); #1;
      clr = 1'b0;
      @(posedge clk); #1;
      obs_q.delete(); exp_q.delete(); obs_st_q.delete(); exp_st_q.delete();
      send_frame(MAC, 64, 1'b0, 1'b0, 1'b1, ST_OK);
      finish_frame(to, held, stuck);
      n_tests++;
      if (to || stuck || obs_q.size() != 32 || obs_st_q.size() != 1 || obs_st_q[0] !== exp_st_q[0]) begin
         n_fail++;
         $display("FAIL clr_recover words=%0d status=%h required 32 words %h", obs_q.size(),
                  obs_st_q[0], exp_st_q[0]);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL clr_recover_word got %h required %h", o, e); end
      end
      obs_q.delete(); exp_q.delete(); obs_st_q.delete(); exp_st_q.delete();
      force dut.drop_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.drop_q;
      send_frame(MAC, 64, 1'b1, 1'b0, 1'b0, ST_GEN);
      finish_frame(to, held, stuck);
      n_tests++;
      if (dropcnt !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL drop_saturate got %h required ffff", dropcnt);
      end
      obs_q.delete(); exp_q.delete(); obs_st_q.delete(); exp_st_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      #1;
      test_reset();
      test_unicast();
      test_broadcast();
      test_errors();
      test_reject_codes();
      test_backpressure();
      test_clr_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
